// File: rtl/product_reg_pkg.sv
// Shared types and width helpers for the product register reader.
package product_reg_pkg;

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  localparam int unsigned DIM_C_DEF     = 1;
  localparam int unsigned DIM_A_DEF     = 8;
  localparam int unsigned ACC_WIDTH_DEF = 32;

  // Index width that stays at least one bit for single-entry dimensions.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned C_IDX_W = idx_w(DIM_C_DEF);
  localparam int unsigned A_IDX_W = idx_w(DIM_A_DEF);

  typedef logic [ACC_WIDTH_DEF-1:0] product_t;

endpackage

// File: rtl/idx_counter_2d.sv
// Row-major (c,a) beat counter; exposes its next value so the reader can prefetch data.
module idx_counter_2d #(
  parameter int unsigned DIM_A = 8,
  parameter int unsigned C_W   = 1,
  parameter int unsigned A_W   = 3,
  parameter int unsigned N_W   = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  input  logic           advance,
  input  logic [N_W-1:0] n,
  output logic [C_W-1:0] c_idx,
  output logic [A_W-1:0] a_idx,
  output logic [C_W-1:0] c_nxt_c,
  output logic [A_W-1:0] a_nxt_c,
  output logic           terminal_c
);

  logic row_end_c;

  assign row_end_c  = (32'(a_idx) == DIM_A - 32'd1);
  assign terminal_c = row_end_c && (32'(c_idx) + 32'd1 == 32'(n));

  // Holds at the terminal entry so the indices never run past n-1 / DIM_A-1.
  always_comb begin
    c_nxt_c = c_idx;
    a_nxt_c = a_idx;
    if (clear) begin
      c_nxt_c = '0;
      a_nxt_c = '0;
    end else if (advance && !terminal_c) begin
      if (row_end_c) begin
        a_nxt_c = '0;
        c_nxt_c = c_idx + C_W'(1);
      end else begin
        a_nxt_c = a_idx + A_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_idx <= '0;
      a_idx <= '0;
    end else begin
      c_idx <= c_nxt_c;
      a_idx <= a_nxt_c;
    end
  end

endmodule

// File: rtl/product_reg_reader.sv
// Drains a snapshot of the DIM_C x DIM_A product array as a valid/ready stream.
module product_reg_reader
  import product_reg_pkg::*;
#(
  parameter int unsigned DIM_C     = DIM_C_DEF,
  parameter int unsigned DIM_A     = DIM_A_DEF,
  parameter int unsigned ACC_WIDTH = ACC_WIDTH_DEF
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [$clog2(DIM_C+1)-1:0]         rows_active,
  input  logic [DIM_C*DIM_A*ACC_WIDTH-1:0]   in_array,
  output logic [ACC_WIDTH-1:0]               out_data,
  output logic [idx_w(DIM_C)-1:0]            out_c_idx,
  output logic [idx_w(DIM_A)-1:0]            out_a_idx,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               out_last,
  output logic                               busy,
  output logic                               done
);

  localparam int unsigned C_W     = idx_w(DIM_C);
  localparam int unsigned A_W     = idx_w(DIM_A);
  localparam int unsigned N_W     = $clog2(DIM_C+1);
  localparam int unsigned ENTRIES = DIM_C * DIM_A;
  localparam int unsigned ARR_W   = ENTRIES * ACC_WIDTH;

  state_t             state_q, state_d;
  logic [ARR_W-1:0]   snap_q;
  logic [N_W-1:0]     n_q, n_clamp_c, n_nxt_c;
  logic [C_W-1:0]     c_nxt_c;
  logic [A_W-1:0]     a_nxt_c;
  logic               terminal_c, fire_c, start_ok_c;
  logic [ARR_W-1:0]   src_c;
  int unsigned        flat_c;
  logic [ACC_WIDTH-1:0] data_d;
  logic               valid_d, last_d, busy_d, done_d;

  assign fire_c     = out_valid && out_ready;
  assign start_ok_c = (state_q == IDLE) && start;
  assign n_clamp_c  = (32'(rows_active) > DIM_C) ? N_W'(DIM_C) : rows_active;
  assign n_nxt_c    = start_ok_c ? n_clamp_c : n_q;

  idx_counter_2d #(
    .DIM_A (DIM_A),
    .C_W   (C_W),
    .A_W   (A_W),
    .N_W   (N_W)
  ) u_idx (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_ok_c),
    .advance    (fire_c),
    .n          (n_q),
    .c_idx      (out_c_idx),
    .a_idx      (out_a_idx),
    .c_nxt_c    (c_nxt_c),
    .a_nxt_c    (a_nxt_c),
    .terminal_c (terminal_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (n_clamp_c != '0) ? STREAM : DONE;
      STREAM:  if (fire_c && terminal_c) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next output values; the first beat reads in_array directly since the snapshot loads on the same edge.
  always_comb begin
    valid_d = (state_d == STREAM);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    last_d  = valid_d && (32'(c_nxt_c) + 32'd1 == 32'(n_nxt_c)) &&
              (32'(a_nxt_c) == DIM_A - 32'd1);
    src_c   = start_ok_c ? in_array : snap_q;
    flat_c  = 32'(c_nxt_c) * DIM_A + 32'(a_nxt_c);
    data_d  = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (i == flat_c) data_d = src_c[i*ACC_WIDTH +: ACC_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      snap_q    <= '0;
      n_q       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (start_ok_c) snap_q <= in_array;
      if (start_ok_c || fire_c) out_data <= data_d;
      n_q       <= n_nxt_c;
      out_valid <= valid_d;
      out_last  <= last_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule
